multi_alu: RTL
==============

Name: multi_alu

Overview:
- Parametrised, registered ALU; successor to the 3-bit-control single-cycle ALU.
- Adds configurable data width, a 4-bit op code (legacy 3-bit codes preserved), logic/shift/unsigned-compare ops, a signed-overflow flag and a valid/busy handshake.
- Optional iterative multiplier spans WIDTH cycles.
- Sits between the register file read ports and the writeback mux of the multi-cycle datapath.

Parameters:
- WIDTH, 32, data width in bits. Power of two, minimum 8.
- SHW, clog2(WIDTH), shift-amount width. Derived, not overridden.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operands/op valid this cycle.
- i_r  input  WIDTH  operand r.
- i_s  input  WIDTH  operand s.
- i_aluc  input  4  operation code.
- o_busy  output  1  high while a multi-cycle op is in flight; new requests ignored.
- o_valid  output  1  one-cycle pulse, result/flags valid.
- o_alu  output  WIDTH  registered result.
- o_zf  output  1  registered zero flag, (o_alu == 0).
- o_of  output  1  registered signed overflow flag.

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE; o_busy=0, o_valid=0, o_alu=0, o_zf=1, o_of=0; multiplier counter and accumulators cleared. Reset wins over any simultaneous i_valid.
- Reset mid-MUL aborts the operation; no o_valid is produced for it.
- Accept: rising edge with i_valid=1 and o_busy=0. i_valid while o_busy=1 is dropped silently.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed).
  - 1000 XOR; 1001 NOR.
  - 1010 SLL: i_r << i_s[SHW-1:0]. 1011 SRL (logical). 1100 SRA (arithmetic); shifts use the same shift-amount field.
  - 1101 SLTU (unsigned).
  - 1110 MUL (see Optional Feature).
  - Any other code: o_alu=0, o_zf=1, o_of=0, o_valid still pulses.
- Single-cycle ops: result and flags registered at the accept edge; o_valid=1 for exactly the following cycle. Back-to-back accepts every cycle are supported, giving one o_valid per accept.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. o_of=1 on signed overflow:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from i_r.
  - o_of=0 for all other ops.
- SLT/SLTU: o_alu = {WIDTH-1 zeros, flag}.
- o_zf is always derived from the registered o_alu value, never from a stale result.
- o_valid=0 on every cycle without a completion. o_alu and flags hold their last values between completions.
- States:
  - IDLE --accept MUL--> MUL. Capture operands, clear accumulator, counter=0, o_busy=1.
  - MUL: one shift-add step per cycle (if multiplier bit 0 is set, add the multiplicand; shift the multiplicand left and the multiplier right). The counter increments.
  - At the edge where counter==WIDTH-1: write the lower WIDTH product bits to o_alu, set o_zf, set o_of=0, o_busy=0, return to IDLE.
  - o_valid pulses in the cycle after that edge, WIDTH cycles after accept. A new request is acceptable in that same cycle.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op 1110 performs the iterative MUL described above. o_busy can assert.
- Undefined: the multiplier datapath, counter and MUL state are not built. 1110 is treated as an undefined op (single cycle, o_alu=0, o_zf=1). o_busy is tied to 0.

Test Plan:
- Reset check, WIDTH=32: assert i_rst for 2 cycles with i_valid=1 -> o_valid=0, o_alu=0, o_zf=1, o_of=0, o_busy=0.
- ADD overflow: ADD 0x7FFFFFFF+0x00000001 -> next cycle o_valid=1, o_alu=0x80000000, o_of=1, o_zf=0. SUB 5-5 -> o_alu=0, o_zf=1, o_of=0.
- Compares and shift: SLT 0xFFFFFFFF vs 0x00000001 -> o_alu=1; SLTU with the same operands -> o_alu=0. SRA 0x80000000 by i_s=4 -> o_alu=0xF8000000.
- Back-to-back: AND, OR, NOR, XOR accepted on 4 consecutive cycles -> 4 consecutive o_valid pulses with correct results; undefined code 0011 -> o_alu=0, o_zf=1.
- MUL with ALU_MUL_EN: MUL 0x00010003*0x00020005 -> o_busy high for 32 cycles, o_valid 32 cycles after accept, o_alu=0x000B000F. An i_valid ADD issued mid-MUL is dropped.
- Reset at MUL cycle 10 -> no o_valid, o_busy=0 next cycle. Without ALU_MUL_EN: MUL -> o_alu=0, o_zf=1 after 1 cycle.

Source files
------------

// File: rtl/multi_alu.sv
// Registered multi-op ALU with a valid/busy handshake and a signed-overflow flag.
// Define ALU_MUL_EN to build the iterative shift-add multiplier behind op 1110.
module multi_alu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_s,
  input  logic [3:0]       i_aluc,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_alu,
  output logic             o_zf,
  output logic             o_of
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res_next;
  logic             of_next;
  logic             accept;

  logic             valid_reg;
  logic [WIDTH-1:0] alu_reg;
  logic             zf_reg;
  logic             of_reg;

  assign shamt = i_s[SHW-1:0];
  assign sum   = i_r + i_s;
  assign diff  = i_r - i_s;

  always_comb begin
    res_next = '0;
    of_next  = 1'b0;
    case (i_aluc)
      OP_AND:  res_next = i_r & i_s;
      OP_OR:   res_next = i_r | i_s;
      OP_ADD: begin
        res_next = sum;
        of_next  = (i_r[WIDTH-1] == i_s[WIDTH-1]) && (sum[WIDTH-1] != i_r[WIDTH-1]);
      end
      OP_SUB: begin
        res_next = diff;
        of_next  = (i_r[WIDTH-1] != i_s[WIDTH-1]) && (diff[WIDTH-1] != i_r[WIDTH-1]);
      end
      OP_SLT:  res_next = {{(WIDTH-1){1'b0}}, ($signed(i_r) < $signed(i_s))};
      OP_XOR:  res_next = i_r ^ i_s;
      OP_NOR:  res_next = ~(i_r | i_s);
      OP_SLL:  res_next = i_r << shamt;
      OP_SRL:  res_next = i_r >> shamt;
      OP_SRA:  res_next = $unsigned($signed(i_r) >>> shamt);
      OP_SLTU: res_next = {{(WIDTH-1){1'b0}}, (i_r < i_s)};
      default: res_next = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MUL    = 1'b1;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [SHW-1:0]   count_reg;
  logic [WIDTH-1:0] step_sum;
  logic             last_step;

  // The final step's partial sum goes straight to o_alu, so the product lands WIDTH edges after accept.
  assign step_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign last_step = (count_reg == SHW'(WIDTH - 1));
  assign o_busy    = (state_reg == MUL);
  assign accept    = i_valid && !o_busy;
`else
  assign o_busy = 1'b0;
  assign accept = i_valid;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_reg  <= 1'b0;
      alu_reg    <= '0;
      zf_reg     <= 1'b1;
      of_reg     <= 1'b0;
`ifdef ALU_MUL_EN
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
`endif
    end else begin
      valid_reg <= 1'b0;
`ifdef ALU_MUL_EN
      if (state_reg == MUL) begin
        acc_reg    <= step_sum;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
        if (last_step) begin
          alu_reg   <= step_sum;
          zf_reg    <= (step_sum == '0);
          of_reg    <= 1'b0;
          valid_reg <= 1'b1;
          state_reg <= IDLE;
        end
      end else if (accept && (i_aluc == OP_MUL)) begin
        state_reg  <= MUL;
        mcand_reg  <= i_r;
        mplier_reg <= i_s;
        acc_reg    <= '0;
        count_reg  <= '0;
      end else
`endif
      if (accept) begin
        alu_reg   <= res_next;
        zf_reg    <= (res_next == '0);
        of_reg    <= of_next;
        valid_reg <= 1'b1;
      end
    end
  end

  assign o_valid = valid_reg;
  assign o_alu   = alu_reg;
  assign o_zf    = zf_reg;
  assign o_of    = of_reg;

endmodule
